hsv_pwm_driver: RTL
===================

# hsv_pwm_driver

Parametrised hue-wheel RGB LED driver: a hue sequencer (run, reverse, hold, manual) feeds a fixed-point HSV-to-RGB converter (S = V = 100 %) whose duties drive three double-buffered PWM channels. It replaces the separate hue-fade and per-channel PWM instances at the top level and drives the RGB LED pins directly. Duty updates are glitch-free: they only take effect at PWM period boundaries.

## Interface
- PWM_INTERVAL, 1200: PWM period in clk cycles (100 µs at 12 MHz).
- HUE_STEPS, 360: hue positions per revolution; must be a multiple of 6.
- STEP_CYCLES, 200000: clk cycles per hue step in run/reverse modes.
- ACTIVE_LOW, 1: 1 = LED on drives pin 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- mode  in  2  00 RUN, 01 HOLD, 10 MANUAL, 11 REVERSE.
- hue_in  in  $clog2(HUE_STEPS)  hue target for MANUAL mode and hue_load.
- hue_load  in  1  single-cycle pulse: hue ← hue_in.
- brightness  in  8  global scale (only with HSV_PWM_BRIGHTNESS_EN).
- hue  out  $clog2(HUE_STEPS)  current hue register.
- period_start  out  1  one-cycle pulse when PWM counter = 0.
- RGB_R, RGB_G, RGB_B  out  1  LED pins, polarity per ACTIVE_LOW.

## Operation
- PWM counter cnt: 0..PWM_INTERVAL-1, free-running, wraps to 0.
- Step timer: counts 0..STEP_CYCLES-1 in RUN/REVERSE and is held at 0 in HOLD/MANUAL. At terminal count: RUN → hue+1 (HUE_STEPS-1 wraps to 0); REVERSE → hue-1 (0 wraps to HUE_STEPS-1).
- MANUAL: hue ← min(hue_in, HUE_STEPS-1) every cycle.
- hue_load applies in every mode and has priority over a step on the same cycle. hue_in ≥ HUE_STEPS is clamped to HUE_STEPS-1.
- Mode change resets the step timer to 0. The hue is kept.
- Conversion: S = HUE_STEPS/6; sector = hue / S; f = hue mod S.
  - up = (f·PWM_INTERVAL)/S, truncated; down = PWM_INTERVAL − up; max = PWM_INTERVAL.
  - Sector 0: R=max, G=up, B=0.
  - Sector 1: R=down, G=max, B=0.
  - Sector 2: R=0, G=max, B=up.
  - Sector 3: R=0, G=down, B=max.
  - Sector 4: R=up, G=0, B=max.
  - Sector 5: R=max, G=0, B=down.
- Duty width is $clog2(PWM_INTERVAL+1) so that full-on is representable.
- Two-stage pipeline (sector/fraction, then duty) into the duty_next registers.
- Double buffer: duty_active ← duty_next only on the cycle cnt = PWM_INTERVAL-1.
- Channel on = (cnt < duty_active). A duty of 0 is never on; a duty of PWM_INTERVAL is always on.
- Pin = on ^ ACTIVE_LOW, registered.

## Timing
- Reset values (sync, rst_n low at a clk edge):
  - cnt, step timer, hue, duty_next, duty_active = 0.
  - period_start = 0.
  - RGB_* = off (1 when ACTIVE_LOW).
- First cycle after reset release: cnt = 0 and period_start = 1. Pins stay off for the first period, because duty_active was 0 at the boundary.
- Hue register updates on the edge after the timer terminal count or hue_load.
- duty_next is valid 2 cycles after a hue change.
- duty_active changes only at the period boundary. Hue-to-pin latency is at most PWM_INTERVAL+3 cycles.
- A pin changes 1 cycle after cnt (registered compare).
- Reset asserted mid-period aborts immediately. All state returns to reset values at that edge.

## Configuration
- HSV_PWM_BRIGHTNESS_EN defined:
  - brightness port present.
  - Duty_next = (duty·(brightness+1)) >> 8, applied in the pipeline's second stage.
  - Latency is unchanged. brightness = 255 gives the exact unscaled duty.
- Undefined: port absent, no scaling, no multiplier inferred.

## Test plan
Parameters for all scenarios: PWM_INTERVAL=12, HUE_STEPS=12, STEP_CYCLES=24, ACTIVE_LOW=1.
1. Reset: hold rst_n=0 for 5 cycles → RGB_R/G/B = 1, hue = 0, period_start = 0. After release and one full period (hue 0): RGB_R = 0 for all 12 cycles, G and B = 1.
2. RUN: hue increments every 24 cycles. After reaching hue 1 (f=1, up=6) and the next boundary: RGB_G = 0 for cnt 0..5 and 1 for cnt 6..11; R = 0 continuously.
3. Wrap: REVERSE from hue 0 → hue = 11 after 24 cycles. Sector 5, down = 6: RGB_B low for 6 of 12 cycles, R always low.
4. Double buffer: in HOLD, hue_load with hue_in=4 at cnt=5 → pins keep the old pattern through cnt=11. From the next cnt=0: G always low, R and B always high.
5. MANUAL with hue_in=15 → hue = 11. Simultaneous hue_load and step terminal in RUN → hue = hue_in, not hue_in+1.
6. With HSV_PWM_BRIGHTNESS_EN, hue 0, brightness=127 → R duty 6 (low 6 of 12 cycles). With brightness=255 → R duty 12.

Source files
------------

// File: rtl/hsv_pwm_driver.sv
// Hue-wheel RGB LED driver: hue sequencer -> two-stage HSV(S=V=1) to duty conversion -> double-buffered PWM pins.
// Optional global brightness scaling is enabled by defining HSV_PWM_BRIGHTNESS_EN.
module hsv_pwm_driver #(
  parameter int PWM_INTERVAL = 1200,
  parameter int HUE_STEPS    = 360,
  parameter int STEP_CYCLES  = 200000,
  parameter int ACTIVE_LOW   = 1,
  localparam int HW = (HUE_STEPS > 1) ? $clog2(HUE_STEPS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [HW-1:0] hue_in,
  input  logic          hue_load,
`ifdef HSV_PWM_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  output logic [HW-1:0] hue,
  output logic          period_start,
  output logic          RGB_R,
  output logic          RGB_G,
  output logic          RGB_B
);

  localparam int CW  = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam int DW  = $clog2(PWM_INTERVAL + 1);
  localparam int TW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int SEG = HUE_STEPS / 6;
  localparam logic OFF = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_HOLD    = 2'b01,
    MODE_MANUAL  = 2'b10,
    MODE_REVERSE = 2'b11
  } mode_e;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [HW-1:0]        hue_q, hue_d;
  mode_e                mode_q, mode_d;
  logic [2:0]           sector_q, sector_d;
  logic [DW-1:0]        up_q, up_d;
  logic [2:0][DW-1:0]   duty_raw;
  logic [2:0][DW-1:0]   duty_next_q, duty_next_d;
  logic [2:0][DW-1:0]   duty_active_q, duty_active_d;
  logic [2:0]           pin_q, pin_d;
  logic                 period_end;
  logic                 step_up, step_dn;
  logic [HW-1:0]        hue_clamped;
  logic [DW-1:0]        duty_max, duty_down;

  assign period_end  = (cnt_q == CW'(PWM_INTERVAL - 1));
  assign hue_clamped = (hue_in > HW'(HUE_STEPS - 1)) ? HW'(HUE_STEPS - 1) : hue_in;

  // PWM counter and hue sequencer; a mode change restarts the step timer.
  always_comb begin
    cnt_d   = period_end ? '0 : cnt_q + CW'(1);
    mode_d  = mode_e'(mode);
    timer_d = timer_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (mode_d != mode_q) begin
      timer_d = '0;
    end else if (mode_d == MODE_RUN || mode_d == MODE_REVERSE) begin
      if (timer_q == TW'(STEP_CYCLES - 1)) begin
        timer_d = '0;
        step_up = (mode_d == MODE_RUN);
        step_dn = (mode_d == MODE_REVERSE);
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      timer_d = '0;
    end

    hue_d = hue_q;
    if (hue_load || mode_d == MODE_MANUAL) begin
      hue_d = hue_clamped;
    end else if (step_up) begin
      hue_d = (hue_q == HW'(HUE_STEPS - 1)) ? '0 : hue_q + HW'(1);
    end else if (step_dn) begin
      hue_d = (hue_q == '0) ? HW'(HUE_STEPS - 1) : hue_q - HW'(1);
    end
  end

  // Stage 1: sector index and rising ramp value for the fraction within it.
  always_comb begin
    sector_d = 3'(32'(hue_q) / 32'(SEG));
    up_d     = DW'(((32'(hue_q) % 32'(SEG)) * 32'(PWM_INTERVAL)) / 32'(SEG));
  end

  // Stage 2: per-sector channel duties, optionally scaled by brightness.
  always_comb begin
    duty_max  = DW'(PWM_INTERVAL);
    duty_down = duty_max - up_q;
    duty_raw  = '0;
    case (sector_q)
      3'd0: begin duty_raw[0] = duty_max;  duty_raw[1] = up_q;      duty_raw[2] = '0;        end
      3'd1: begin duty_raw[0] = duty_down; duty_raw[1] = duty_max;  duty_raw[2] = '0;        end
      3'd2: begin duty_raw[0] = '0;        duty_raw[1] = duty_max;  duty_raw[2] = up_q;      end
      3'd3: begin duty_raw[0] = '0;        duty_raw[1] = duty_down; duty_raw[2] = duty_max;  end
      3'd4: begin duty_raw[0] = up_q;      duty_raw[1] = '0;        duty_raw[2] = duty_max;  end
      3'd5: begin duty_raw[0] = duty_max;  duty_raw[1] = '0;        duty_raw[2] = duty_down; end
      default: duty_raw = '0;
    endcase

    for (int i = 0; i < 3; i++) begin
`ifdef HSV_PWM_BRIGHTNESS_EN
      // d*(b+1) >> 8 written as (d*b + d) >> 8 so b = 255 returns d exactly.
      duty_next_d[i] = DW'((((DW+9)'(duty_raw[i]) * (DW+9)'(brightness)) + (DW+9)'(duty_raw[i])) >> 8);
`else
      duty_next_d[i] = duty_raw[i];
`endif
    end
  end

  // Duties swap only at the last count of a period, so each period is glitch-free.
  always_comb begin
    duty_active_d = period_end ? duty_next_q : duty_active_q;
    for (int i = 0; i < 3; i++) begin
      pin_d[i] = (DW'(cnt_q) < duty_active_q[i]) ^ OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      timer_q       <= '0;
      hue_q         <= '0;
      mode_q        <= MODE_RUN;
      sector_q      <= '0;
      up_q          <= '0;
      duty_next_q   <= '0;
      duty_active_q <= '0;
      pin_q         <= {3{OFF}};
    end else begin
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      hue_q         <= hue_d;
      mode_q        <= mode_d;
      sector_q      <= sector_d;
      up_q          <= up_d;
      duty_next_q   <= duty_next_d;
      duty_active_q <= duty_active_d;
      pin_q         <= pin_d;
    end
  end

  // Gated by rst_n so the pulse is low while reset is held and high on the first free cycle.
  assign period_start = rst_n & (cnt_q == '0);
  assign hue          = hue_q;
  assign RGB_R        = pin_q[0];
  assign RGB_G        = pin_q[1];
  assign RGB_B        = pin_q[2];

endmodule
